// File: rtl/btb_pkg.sv
// Shared helpers for the fetch-stage branch/return predictor: pointer width
// derivation and saturating-counter reference values.
package btb_pkg;

    // Width of an index into a table of n entries; never narrower than 1 bit.
    function automatic int ptr_w(input int n);
        ptr_w = (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter value written on allocation: the weakly-taken state (MSB set, rest clear).
    function automatic int cnt_weak_taken(input int cnt_w);
        cnt_weak_taken = 32'sd1 << (cnt_w - 1);
    endfunction

    // Saturation ceiling of an unsigned counter of cnt_w bits.
    function automatic int cnt_max(input int cnt_w);
        cnt_max = (32'sd1 << cnt_w) - 32'sd1;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return address stack. A push on a full stack silently replaces the
// oldest entry; a pop on an empty stack is ignored; push+pop together replaces
// the top in place (or acts as a plain push when empty).
module ras_stack
    import btb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ADR_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [ADR_W-1:0] din,
    output logic [ADR_W-1:0] top,
    output logic             empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [ADR_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] top_r;
    logic [PTR_W:0]   count_r;
    logic             empty_r;

    logic [PTR_W-1:0] top_next_s;
    logic [PTR_W:0]   count_next_s;
    logic             wr_en_s;
    logic [PTR_W-1:0] wr_idx_s;

    // Next top pointer, occupancy and write slot for the requested operation.
    always_comb begin
        top_next_s   = top_r;
        count_next_s = count_r;
        wr_en_s      = 1'b0;
        wr_idx_s     = top_r;
        case ({push, pop})
            2'b10: begin
                top_next_s   = top_r + PTR_W'(1'b1);
                wr_idx_s     = top_r + PTR_W'(1'b1);
                wr_en_s      = 1'b1;
                count_next_s = (count_r == CNT_FULL) ? count_r : count_r + (PTR_W + 1)'(1'b1);
            end
            2'b01: begin
                if (count_r != {(PTR_W + 1){1'b0}}) begin
                    top_next_s   = top_r - PTR_W'(1'b1);
                    count_next_s = count_r - (PTR_W + 1)'(1'b1);
                end else begin
                    top_next_s   = top_r;
                    count_next_s = count_r;
                end
            end
            2'b11: begin
                if (count_r == {(PTR_W + 1){1'b0}}) begin
                    top_next_s   = top_r + PTR_W'(1'b1);
                    wr_idx_s     = top_r + PTR_W'(1'b1);
                    wr_en_s      = 1'b1;
                    count_next_s = count_r + (PTR_W + 1)'(1'b1);
                end else begin
                    wr_idx_s     = top_r;
                    wr_en_s      = 1'b1;
                end
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Stack storage, pointer, occupancy and registered empty flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ADR_W{1'b0}};
            end
            top_r   <= {PTR_W{1'b0}};
            count_r <= {(PTR_W + 1){1'b0}};
            empty_r <= 1'b1;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_idx_s] <= din;
            end
            top_r   <= top_next_s;
            count_r <= count_next_s;
            empty_r <= (count_next_s == {(PTR_W + 1){1'b0}});
        end
    end

    assign top   = mem_r[top_r];
    assign empty = empty_r;

endmodule

// File: rtl/btb_ras_predictor.sv
// Fetch-stage branch target buffer with per-entry saturating counters and a
// return address stack. Lookup is combinational against the current state;
// training from decode happens on the clock edge when UPDATE_EN_SD is high.
module btb_ras_predictor
    import btb_pkg::*;
#(
    parameter int N_ENTRIES = 8,
    parameter int CNT_W     = 2,
    parameter int RAS_DEPTH = 8,
    parameter int ADR_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADR_W-1:0] PC_RD,
    output logic             PRED_TAKEN_SI,
    output logic [ADR_W-1:0] PRED_ADR_SI,
    input  logic             UPDATE_EN_SD,
    input  logic             BRANCH_INST_RD,
    input  logic             BRANCH_TAKEN_RD,
    input  logic [ADR_W-1:0] BRANCH_INST_ADR_RD,
    input  logic [ADR_W-1:0] ADR_TO_BRANCH_RD,
    input  logic             RET_INST_RD,
    input  logic             PUSH_ADR_RAS_RD,
    input  logic             POP_ADR_RAS_RD,
    input  logic [ADR_W-1:0] ADR_TO_RET_RD,
    output logic             RAS_EMPTY_SI
);

    localparam int IDX_W = ptr_w(N_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_weak_taken(CNT_W));
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef struct packed {
        logic             valid;
        logic             is_ret;
        logic [ADR_W-1:0] tag;
        logic [ADR_W-1:0] target;
        logic [CNT_W-1:0] counter;
    } btb_entry_t;

    localparam btb_entry_t ENTRY_CLR = btb_entry_t'({$bits(btb_entry_t){1'b0}});

    btb_entry_t       btb_r [N_ENTRIES];
    logic [IDX_W-1:0] alloc_ptr_r;

    logic             lk_hit_s;
    logic [IDX_W-1:0] lk_idx_s;
    logic             up_hit_s;
    logic [IDX_W-1:0] up_idx_s;
    logic [CNT_W-1:0] cnt_cur_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             ras_push_s;
    logic             ras_pop_s;
    logic [ADR_W-1:0] ras_top_s;
    logic             ras_empty_s;

    // Priority encoders for fetch lookup and training lookup; lowest index wins.
    always_comb begin
        lk_hit_s = 1'b0;
        lk_idx_s = {IDX_W{1'b0}};
        up_hit_s = 1'b0;
        up_idx_s = {IDX_W{1'b0}};
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (btb_r[i].valid && (btb_r[i].tag == PC_RD)) begin
                lk_hit_s = 1'b1;
                lk_idx_s = IDX_W'(i);
            end else begin
                lk_hit_s = lk_hit_s;
            end
            if (btb_r[i].valid && (btb_r[i].tag == BRANCH_INST_ADR_RD)) begin
                up_hit_s = 1'b1;
                up_idx_s = IDX_W'(i);
            end else begin
                up_hit_s = up_hit_s;
            end
        end
    end

    // Prediction: branches follow the counter MSB, returns follow the RAS top.
    always_comb begin
        PRED_TAKEN_SI = 1'b0;
        PRED_ADR_SI   = {ADR_W{1'b0}};
        if (lk_hit_s) begin
            if (btb_r[lk_idx_s].is_ret) begin
                if (!ras_empty_s) begin
                    PRED_TAKEN_SI = 1'b1;
                    PRED_ADR_SI   = ras_top_s;
                end else begin
                    PRED_TAKEN_SI = 1'b0;
                end
            end else begin
                if (btb_r[lk_idx_s].counter[CNT_W-1]) begin
                    PRED_TAKEN_SI = 1'b1;
                    PRED_ADR_SI   = btb_r[lk_idx_s].target;
                end else begin
                    PRED_TAKEN_SI = 1'b0;
                end
            end
        end else begin
            PRED_TAKEN_SI = 1'b0;
        end
    end

    // Saturating counter step for the entry hit by the resolving branch.
    always_comb begin
        cnt_cur_s  = btb_r[up_idx_s].counter;
        cnt_next_s = cnt_cur_s;
        if (BRANCH_TAKEN_RD) begin
            if (cnt_cur_s != CNT_SAT) begin
                cnt_next_s = cnt_cur_s + CNT_W'(1'b1);
            end else begin
                cnt_next_s = cnt_cur_s;
            end
        end else begin
            if (cnt_cur_s != CNT_ZERO) begin
                cnt_next_s = cnt_cur_s - CNT_W'(1'b1);
            end else begin
                cnt_next_s = cnt_cur_s;
            end
        end
    end

    // BTB training and round-robin allocation; a return resolve takes precedence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                btb_r[i] <= ENTRY_CLR;
            end
            alloc_ptr_r <= {IDX_W{1'b0}};
        end else if (UPDATE_EN_SD) begin
            if (RET_INST_RD) begin
                if (!up_hit_s) begin
                    btb_r[alloc_ptr_r] <= '{valid: 1'b1, is_ret: 1'b1, tag: BRANCH_INST_ADR_RD,
                                            target: {ADR_W{1'b0}}, counter: CNT_ZERO};
                    alloc_ptr_r        <= alloc_ptr_r + IDX_W'(1'b1);
                end
            end else if (BRANCH_INST_RD) begin
                if (up_hit_s) begin
                    btb_r[up_idx_s].counter <= cnt_next_s;
                    if (BRANCH_TAKEN_RD) begin
                        btb_r[up_idx_s].target <= ADR_TO_BRANCH_RD;
                    end
                end else if (BRANCH_TAKEN_RD) begin
                    btb_r[alloc_ptr_r] <= '{valid: 1'b1, is_ret: 1'b0, tag: BRANCH_INST_ADR_RD,
                                            target: ADR_TO_BRANCH_RD, counter: CNT_INIT};
                    alloc_ptr_r        <= alloc_ptr_r + IDX_W'(1'b1);
                end
            end
        end
    end

    assign ras_push_s = UPDATE_EN_SD & PUSH_ADR_RAS_RD;
    assign ras_pop_s  = UPDATE_EN_SD & POP_ADR_RAS_RD;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .ADR_W (ADR_W)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push_s),
        .pop   (ras_pop_s),
        .din   (ADR_TO_RET_RD),
        .top   (ras_top_s),
        .empty (ras_empty_s)
    );

    assign RAS_EMPTY_SI = ras_empty_s;

endmodule
